circular_shift_register_universal: RTL and testbench
====================================================

Name: circular_shift_register_universal

Overview:
- Parametrised universal circular shift register: configurable width, right/left rotation, serial insertion, parallel load.
- Adds a multi-step rotate command: a start/amount request runs under an internal FSM with busy/done handshake.
- Used in the register-file and datapath exercises as the general-purpose successor to the fixed 5-bit right-rotate register.

Parameters:
WIDTH, 5, register width in bits (legal: WIDTH >= 2)
COUNT_WIDTH, 3, width of the rotate-amount input and internal step counter

Ports:
clock  input  1  rising-edge clock
clear  input  1  asynchronous, active-low reset
mode  input  2  single-step operation in IDLE: 00 hold, 01 rotate right, 10 rotate left, 11 parallel load
serial_en  input  1  1 = incoming bit taken from data instead of the wrapped bit
data  input  1  serial input bit
load_value  input  WIDTH  parallel load value (mode 11)
start  input  1  request multi-step rotate; direction taken from mode (01/10)
amount  input  COUNT_WIDTH  number of steps for multi-step rotate
q  output  WIDTH  register contents; q[WIDTH-1] is the leftmost bit
out  output  1  serial output, always q[0]
busy  output  1  high while a multi-step rotate is running
done  output  1  one-cycle pulse when a multi-step rotate completes

Behaviour:
- Reset (clear=0, asynchronous): q=0, busy=0, done=0, counter=0, FSM=IDLE. Reset during RUN aborts the operation; no done pulse follows.
- Right step: q <= {in, q[WIDTH-1:1]}, where in = serial_en ? data : q[0].
- Left step: q <= {q[WIDTH-2:0], in}, where in = serial_en ? data : q[WIDTH-1].
- FSM states: IDLE and RUN.
- IDLE, start=1 with mode 01 or 10 (start has priority over the single-step op):
  - amount>0: latch direction from mode and counter=amount; busy=1 next cycle; q unchanged on this edge; go to RUN.
  - amount=0: no shift, stay IDLE, busy stays 0, done=1 on the next cycle.
- IDLE, start=1 with mode 00 or 11: start is ignored; the mode operation executes normally.
- IDLE, start=0: one mode operation per clock edge. Mode 11 sets q <= load_value.
- RUN: each edge performs one step in the latched direction, honouring the live serial_en/data, and decrements counter.
  - When counter goes 1->0 on an edge: that edge does the last shift, and busy->0, done->1, FSM->IDLE.
  - mode, start, load_value and amount are ignored during RUN.
- Latency: start accepted at edge k; shifts occur at edges k+1..k+amount; done is high for the cycle after edge k+amount.
- done is high for exactly one cycle and deasserts on the following edge.
- A new start may be accepted on the edge where done deasserts (back-to-back).
- amount >= WIDTH is legal: WIDTH steps with serial_en=0 restore the original value.
- counter never underflows.
- out = q[0] combinationally, in every state.

Test Plan:
- WIDTH=5: mode=11, load_value=10110 -> q=10110; mode=01, one edge -> q=01011, out=1.
- q=10000, start=1, mode=01, amount=3 -> busy=1 for 3 cycles, q steps 01000, 00100, 00010; done pulses once; q holds after.
- q=10011, start=1, mode=10, amount=5, serial_en=0 -> q returns to 10011 after 5 steps; done pulses exactly once.
- q=11111, mode=01, serial_en=1, data=0, 5 edges -> q goes 01111 to 00000; out sequence 1,1,1,1,1 then 0.
- start with amount=0 -> q unchanged, busy never high, done pulses the next cycle; start with mode=11 -> parallel load occurs, busy stays 0.
- Run amount=6, assert clear=0 after 2 shifts -> q=00000 and busy=0 immediately (asynchronous); no done pulse after clear releases; a new start is accepted normally.

Source files
------------

// File: rtl/circular_shift_register_universal.sv
// Universal circular shift register: rotate right/left with optional serial insertion,
// parallel load, and a counted multi-step rotate with busy/done handshake.
module circular_shift_register_universal #(
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned COUNT_WIDTH = 3
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic [1:0]             mode,
  input  logic                   serial_en,
  input  logic                   data,
  input  logic [WIDTH-1:0]       load_value,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] amount,
  output logic [WIDTH-1:0]       q,
  output logic                   out,
  output logic                   busy,
  output logic                   done
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   dir_left_q, dir_left_d;
  logic [WIDTH-1:0]       q_d;
  logic                   busy_d, done_d;
  logic [WIDTH-1:0]       rot_right, rot_left;

  // One-step results; the inserted bit is either the wrapped bit or the serial input.
  always_comb begin
    rot_right = {(serial_en ? data : q[0]), q[WIDTH-1:1]};
    rot_left  = {q[WIDTH-2:0], (serial_en ? data : q[WIDTH-1])};
  end

  assign out = q[0];

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dir_left_q <= 1'b0;
      q          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dir_left_q <= dir_left_d;
      q          <= q_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_left_d = dir_left_q;
    q_d        = q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && (mode == MODE_RIGHT || mode == MODE_LEFT)) begin
          // A zero-length request completes immediately without touching q.
          if (amount != '0) begin
            state_d    = RUN;
            cnt_d      = amount;
            dir_left_d = (mode == MODE_LEFT);
            busy_d     = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          unique case (mode)
            MODE_HOLD:  q_d = q;
            MODE_RIGHT: q_d = rot_right;
            MODE_LEFT:  q_d = rot_left;
            MODE_LOAD:  q_d = load_value;
          endcase
        end
      end
      RUN: begin
        q_d = dir_left_q ? rot_left : rot_right;
        if (cnt_q <= COUNT_WIDTH'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q - COUNT_WIDTH'(1);
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_circular_shift_register_universal.sv
// Scoreboard bench: each driven edge pushes its predicted q/busy/done; the sample after the edge pops and compares.
module tb_circular_shift_register_universal;

  localparam int unsigned W  = 5;
  localparam int unsigned CW = 3;

  logic          clock = 1'b0;
  logic          clear;
  logic [1:0]    mode;
  logic          serial_en;
  logic          data;
  logic [W-1:0]  load_value;
  logic          start;
  logic [CW-1:0] amount;
  logic [W-1:0]  q;
  logic          out;
  logic          busy;
  logic          done;

  circular_shift_register_universal #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .clear(clear), .mode(mode), .serial_en(serial_en), .data(data),
    .load_value(load_value), .start(start), .amount(amount),
    .q(q), .out(out), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] q;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference state
  logic [W-1:0] m_q;
  bit           m_run, m_dir_left;
  int           m_left;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] step_r(input logic [W-1:0] v, input logic se, input logic d);
    logic b;
    b = se ? d : v[0];
    return {b, v[W-1:1]};
  endfunction

  function automatic logic [W-1:0] step_l(input logic [W-1:0] v, input logic se, input logic d);
    logic b;
    b = se ? d : v[W-1];
    return {v[W-2:0], b};
  endfunction

  // Predict the effect of the coming edge and queue it, then sample the DUT after the edge.
  task automatic tick();
    exp_t e;
    e.busy = 1'b0;
    e.done = 1'b0;
    if (m_run) begin
      m_q = m_dir_left ? step_l(m_q, serial_en, data) : step_r(m_q, serial_en, data);
      m_left--;
      if (m_left == 0) begin
        m_run  = 0;
        e.done = 1'b1;
      end else begin
        e.busy = 1'b1;
      end
    end else if (start && (mode == 2'b01 || mode == 2'b10)) begin
      if (amount == 0) e.done = 1'b1;
      else begin
        m_run      = 1;
        m_left     = int'(amount);
        m_dir_left = (mode == 2'b10);
        e.busy     = 1'b1;
      end
    end else begin
      case (mode)
        2'b01:   m_q = step_r(m_q, serial_en, data);
        2'b10:   m_q = step_l(m_q, serial_en, data);
        2'b11:   m_q = load_value;
        default: m_q = m_q;
      endcase
    end
    e.q = m_q;
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("q", 32'(q), 32'(e.q));
      check("out", 32'(out), 32'(e.q[0]));
      check("busy", 32'(busy), 32'(e.busy));
      check("done", 32'(done), 32'(e.done));
    end
  endtask

  task automatic load(input logic [W-1:0] v);
    start = 0; mode = 2'b11; load_value = v; tick();
    mode = 2'b00;
  endtask

  task automatic model_reset();
    m_q = '0; m_run = 0; m_dir_left = 0; m_left = 0;
    sb.delete();
  endtask

  initial begin
    int guard;
    mode = 2'b00; serial_en = 0; data = 0; load_value = '0; start = 0; amount = '0;
    clear = 0;
    model_reset();
    #12;
    check("rst_q", 32'(q), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    clear = 1;
    tick();

    // Load then a single right rotate
    load(5'b10110);
    check("load_lit", 32'(q), 32'(5'b10110));
    mode = 2'b01; tick(); mode = 2'b00;
    check("ror_lit", 32'(q), 32'(5'b01011));
    check("ror_out", 32'(out), 32'd1);

    // Multi-step right by 3; mode/start/load changes during RUN must be ignored
    load(5'b10000);
    start = 1; mode = 2'b01; amount = 3; tick();
    start = 0; mode = 2'b00;
    check("acc_q", 32'(q), 32'(5'b10000));
    tick(); check("r3_1", 32'(q), 32'(5'b01000));
    start = 1; mode = 2'b11; load_value = 5'b11111; amount = 7;
    tick(); check("r3_2", 32'(q), 32'(5'b00100));
    start = 0; mode = 2'b00;
    tick(); check("r3_3", 32'(q), 32'(5'b00010));
    check("r3_done", 32'(done), 32'd1);
    tick(); check("r3_hold", 32'(q), 32'(5'b00010));

    // Left by WIDTH restores value
    load(5'b10011);
    start = 1; mode = 2'b10; amount = 5; serial_en = 0; tick();
    start = 0; mode = 2'b00;
    for (int i = 0; i < 5; i++) tick();
    check("l5_lit", 32'(q), 32'(5'b10011));
    check("l5_done", 32'(done), 32'd1);
    tick();

    // Serial zero fill
    load(5'b11111);
    mode = 2'b01; serial_en = 1; data = 0;
    for (int i = 0; i < 5; i++) begin
      check("fill_out", 32'(out), 32'd1);
      tick();
    end
    check("fill_out_end", 32'(out), 32'd0);
    check("fill_q", 32'(q), 32'd0);
    mode = 2'b00; serial_en = 0;

    // amount=0 and start with load mode
    load(5'b01101);
    start = 1; mode = 2'b01; amount = 0; tick();
    check("a0_q", 32'(q), 32'(5'b01101));
    check("a0_done", 32'(done), 32'd1);
    mode = 2'b11; load_value = 5'b10101; tick();
    check("sld_q", 32'(q), 32'(5'b10101));
    check("sld_busy", 32'(busy), 32'd0);
    start = 0; mode = 2'b00;

    // Back-to-back: new start on the edge where done drops
    start = 1; mode = 2'b01; amount = 2; tick();
    start = 0; mode = 2'b00;
    guard = 0;
    while (!done && guard < 20) begin tick(); guard++; end
    if (guard >= 20) check("b2b_timeout", 32'd1, 32'd0);
    start = 1; mode = 2'b10; amount = 1; tick();
    check("b2b_busy", 32'(busy), 32'd1);
    start = 0; mode = 2'b00;
    tick(); tick();

    // Asynchronous clear mid-run
    load(5'b11001);
    start = 1; mode = 2'b01; amount = 6; tick();
    start = 0; mode = 2'b00;
    tick(); tick();
    #2 clear = 0;
    #1;
    check("aclr_q", 32'(q), 32'd0);
    check("aclr_busy", 32'(busy), 32'd0);
    model_reset();
    #3 clear = 1;
    for (int i = 0; i < 4; i++) tick();
    start = 1; mode = 2'b10; amount = 2; serial_en = 1; data = 1; tick();
    start = 0; mode = 2'b00;
    tick(); tick(); tick();
    check("post_q", 32'(q), 32'(5'b00011));
    serial_en = 0; data = 0;

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      mode       = 2'($urandom_range(0, 3));
      serial_en  = 1'($urandom_range(0, 1));
      data       = 1'($urandom_range(0, 1));
      load_value = W'($urandom);
      start      = ($urandom_range(0, 3) == 0);
      amount     = CW'($urandom_range(0, 7));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
